// File: rtl/lsu_writeback.sv
// Load/store unit: runs one memory access per request over a req/ack handshake,
// aligns store strobes/data and writes extended load data back to the register file.
`timescale 1ns/1ps
module lsu_writeback #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [XLEN-1:0]   store_data,
    input  logic [4:0]        rd_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        off_q, off_d;
    logic [4:0]        rd_q, rd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic              req_legal;
    logic              req_aligned;
    logic [3:0]        st_strb;
    logic [XLEN-1:0]   st_data;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_ext;

    // Request decode: funct3[1:0] is the access size for both loads and stores.
    always_comb begin
        req_legal   = is_store ? (funct3 inside {3'b000, 3'b001, 3'b010})
                               : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req_aligned = 1'b1;
        st_strb     = 4'b1111;
        st_data     = store_data;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                req_aligned = ~addr[0];
                st_strb     = 4'b0011 << addr[1:0];
                st_data     = {2{store_data[15:0]}};
            end
            default: req_aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Load lane select and extension from the latched request.
    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        wb_we_d     = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    off_d      = addr[1:0];
                    rd_d       = rd_in;
                    if (req_legal && req_aligned) begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store;
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_d = st_data;
                        mem_wstrb_d = is_store ? st_strb : 4'b0000;
                    end else begin
                        // Rejected requests skip memory and report through FIN.
                        state_d = FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        wb_rd_d = rd_in;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = FIN;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    done_d    = 1'b1;
                    wb_rd_d   = rd_q;
                    if (!is_store_q) begin
                        wb_data_d = ld_ext;
                        wb_we_d   = (rd_q != 5'd0);
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'd0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_we     = wb_we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// Self-checking bench for lsu_writeback: directed cases plus randomized
// transactions checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_lsu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        busy, done, err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int checks = 0;
    int errors = 0;
    int req_count = 0;
    logic req_seen = 1'b0;

    lsu_writeback #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .rd_in(rd_in), .busy(busy), .done(done),
        .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // Count distinct memory request transactions (rising mem_req).
    always @(negedge clk) begin
        if (mem_req && !req_seen) req_count++;
        req_seen = mem_req;
    end

    function automatic bit model_legal(input logic st, input logic [2:0] f3, input logic [1:0] off);
        int sz;
        bit ok;
        sz = int'(f3) % 4;
        if (st) ok = (f3 <= 3'd2);
        else    ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        if (sz == 1 && (int'(off) % 2) != 0) ok = 1'b0;
        if (sz == 2 && off != 2'd0) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rdata);
        logic [31:0] sh, v;
        sh = rdata >> (8 * int'(off));
        case (f3)
            3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'd4: v = sh & 32'hFF;
            3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'd5: v = sh & 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] off);
        int nbytes;
        nbytes = 1 << (int'(f3) % 4);
        return 4'(((1 << nbytes) - 1) << int'(off));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'd0) return (sd & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h00010001;
        return sd;
    endfunction

    // One complete transaction starting in an IDLE cycle; ends in the next IDLE cycle.
    task automatic do_txn(input string nm, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] rdata, input int waits, input bit hold_start,
                          output logic [31:0] got_data);
        bit legal;
        logic exp_we;
        int req_before;
        logic [3:0] exp_strb;
        legal      = model_legal(st, f3, a[1:0]);
        exp_we     = !st && (rd != 5'd0);
        exp_strb   = st ? model_strb(f3, a[1:0]) : 4'b0000;
        req_before = req_count;
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = rd;
        @(posedge clk); #1;
        if (hold_start) begin
            addr = $urandom; store_data = $urandom; rd_in = 5'($urandom);
        end else begin
            start = 1'b0;
        end
        if (!legal) begin
            checks++;
            if ({mem_req, done, err, wb_we, busy} !== 5'b01101) begin
                errors++;
                $display("FAIL %s err-path req/done/err/we/busy got %b exp 01101", nm,
                         {mem_req, done, err, wb_we, busy});
            end
        end else begin
            checks++;
            if ({mem_req, mem_we, mem_addr, mem_wstrb, done, busy} !==
                {1'b1, st, a & 32'hFFFF_FFFC, exp_strb, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s req got req=%b we=%b addr=%h strb=%b done=%b exp we=%b addr=%h strb=%b",
                         nm, mem_req, mem_we, mem_addr, mem_wstrb, done, st,
                         a & 32'hFFFF_FFFC, exp_strb);
            end
            if (st) begin
                checks++;
                if (mem_wdata !== model_wdata(f3, sd)) begin
                    errors++;
                    $display("FAIL %s wdata got %h exp %h", nm, mem_wdata, model_wdata(f3, sd));
                end
            end
            for (int i = 0; i < waits; i++) begin
                @(posedge clk); #1;
                checks++;
                if ({mem_req, mem_addr, mem_wstrb, done} !== {1'b1, a & 32'hFFFF_FFFC, exp_strb, 1'b0}) begin
                    errors++;
                    $display("FAIL %s hold cycle %0d req=%b addr=%h strb=%b done=%b", nm, i,
                             mem_req, mem_addr, mem_wstrb, done);
                end
            end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            checks++;
            if ({done, err, wb_we, mem_req, busy} !== {1'b1, 1'b0, exp_we, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s fin done/err/we/req/busy got %b exp %b", nm,
                         {done, err, wb_we, mem_req, busy}, {1'b1, 1'b0, exp_we, 1'b0, 1'b1});
            end
            if (exp_we) begin
                checks++;
                if ({wb_rd, wb_data} !== {rd, model_load(f3, a[1:0], rdata)}) begin
                    errors++;
                    $display("FAIL %s wb got rd=%0d data=%h exp rd=%0d data=%h", nm, wb_rd,
                             wb_data, rd, model_load(f3, a[1:0], rdata));
                end
            end
        end
        got_data = wb_data;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, err, wb_we, busy, mem_req} !== 5'b00000) begin
            errors++;
            $display("FAIL %s post done/err/we/busy/req got %b exp 00000", nm,
                     {done, err, wb_we, busy, mem_req});
        end
        checks++;
        if (req_count !== req_before + (legal ? 1 : 0)) begin
            errors++;
            $display("FAIL %s req transactions got %0d exp %0d", nm, req_count - req_before,
                     legal ? 1 : 0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0;
        store_data = '0; rd_in = '0; mem_ack = 1'b0; mem_rdata = '0;
        #2;
        checks++;
        if ({busy, done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_we, wb_rd, wb_data} !== '0) begin
            errors++;
            $display("FAIL reset outputs not zero busy=%b req=%b addr=%h wb=%h", busy, mem_req,
                     mem_addr, wb_data);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset idle busy got %b exp 0", busy);
        end
    endtask

    task automatic test_lw();
        logic [31:0] d;
        do_txn("lw", 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF, 3, 1'b0, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL lw data got %h exp deadbeef", d);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] d;
        do_txn("lb", 1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h80123456, 1, 1'b0, d);
        checks++;
        if (d !== 32'hFFFFFF80) begin errors++; $display("FAIL lb data got %h exp ffffff80", d); end
        do_txn("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 5'd8, 32'h80123456, 0, 1'b0, d);
        checks++;
        if (d !== 32'h00000080) begin errors++; $display("FAIL lbu data got %h exp 00000080", d); end
        do_txn("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 32'h80123456, 2, 1'b0, d);
        checks++;
        if (d !== 32'h00008012) begin errors++; $display("FAIL lhu data got %h exp 00008012", d); end
    endtask

    task automatic test_store();
        logic [31:0] d;
        start = 1'b1; is_store = 1'b1; funct3 = 3'b000; addr = 32'h202;
        store_data = 32'h000000A5; rd_in = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata} !== {1'b1, 1'b1, 32'h200, 4'b0100, 32'hA5A5A5A5}) begin
            errors++;
            $display("FAIL sb req got we=%b addr=%h strb=%b wdata=%h exp 1 200 0100 a5a5a5a5",
                     mem_we, mem_addr, mem_wstrb, mem_wdata);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++;
        if ({done, err, wb_we, mem_req} !== 4'b1000) begin
            errors++;
            $display("FAIL sb fin done/err/we/req got %b exp 1000", {done, err, wb_we, mem_req});
        end
        @(posedge clk); #1;
        do_txn("sh", 1'b1, 3'b001, 32'h306, 32'h1234ABCD, 5'd4, 32'h0, 1, 1'b0, d);
        do_txn("sw", 1'b1, 3'b010, 32'h40C, 32'hCAFEF00D, 5'd4, 32'h0, 0, 1'b0, d);
    endtask

    task automatic test_misaligned();
        logic [31:0] d;
        do_txn("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 5'd6, 32'h0, 0, 1'b0, d);
        do_txn("sh_mis", 1'b1, 3'b001, 32'h101, 32'h55, 5'd6, 32'h0, 0, 1'b0, d);
        do_txn("ld_f3_3", 1'b0, 3'b011, 32'h100, 32'h0, 5'd6, 32'h0, 0, 1'b0, d);
        do_txn("st_f3_4", 1'b1, 3'b100, 32'h100, 32'h0, 5'd6, 32'h0, 0, 1'b0, d);
    endtask

    task automatic test_rd0_busy();
        logic [31:0] d;
        do_txn("rd0", 1'b0, 3'b010, 32'h500, 32'h0, 5'd0, 32'h13572468, 2, 1'b0, d);
        do_txn("busy_start", 1'b0, 3'b000, 32'h601, 32'h0, 5'd12, 32'h0000C300, 3, 1'b1, d);
    endtask

    task automatic test_ack_idle();
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        checks++;
        if ({busy, done, wb_we, mem_req} !== 4'b0000) begin
            errors++;
            $display("FAIL ack_idle busy/done/we/req got %b exp 0000", {busy, done, wb_we, mem_req});
        end
    endtask

    task automatic test_reset_mid_req();
        logic [31:0] d;
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h700; rd_in = 5'd9;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_we, wb_rd, wb_data} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs req=%b busy=%b addr=%h wb_rd=%0d wb_data=%h", mem_req,
                     busy, mem_addr, wb_rd, wb_data);
        end
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++;
        if ({done, wb_we, mem_req} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid held done/we/req got %b exp 000", {done, wb_we, mem_req});
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        do_txn("lw_after_rst", 1'b0, 3'b010, 32'h704, 32'h0, 5'd10, 32'h0BADF00D, 1, 1'b0, d);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = 32'h1000 + ($urandom & 32'h0FFF);
            do_txn("rand", 1'($urandom), 3'($urandom), a, $urandom, 5'($urandom), $urandom,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_store();
        test_misaligned();
        test_rd0_busy();
        test_ack_idle();
        test_reset_mid_req();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_writeback.md
Name: lsu_writeback

Overview:
- Load/store unit that is the writer into the rv32i register file's write port (we/rd/data_in).
- Accepts one memory instruction at a time from the core and runs a req/ack handshake to data memory.
- Aligns stores into byte strobes; aligns and sign- or zero-extends load data.
- For loads, issues a single-cycle register write-back (wb_we/wb_rd/wb_data).

Parameters:
- ADDR_W, 32, memory address width.
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request valid; accepted only when busy=0.
- is_store  in  1  1 = store, 0 = load.
- funct3  in  3  loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- addr  in  ADDR_W  effective byte address.
- store_data  in  XLEN  rs2 value.
- rd_in  in  5  destination register index.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, for misaligned or illegal funct3.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address, {addr[ADDR_W-1:2],2'b00}.
- mem_wdata  out  XLEN  replicated store data.
- mem_wstrb  out  4  byte enables; 0000 on reads.
- mem_ack  in  1  memory completion; rdata valid in the same cycle.
- mem_rdata  in  XLEN  read word.
- wb_we  out  1  register-file write enable.
- wb_rd  out  5  register-file destination.
- wb_data  out  XLEN  register-file write data.

Behaviour:
- Reset (async, immediate): state=IDLE. busy, done, err, mem_req, mem_we, wb_we = 0. mem_addr, mem_wdata, mem_wstrb, wb_rd, wb_data = 0.
- States are IDLE, REQ, FIN.
- IDLE: on a clock edge with start=1, latch is_store, funct3, addr, store_data and rd_in.
  - Legal and aligned: go to REQ.
  - Otherwise: go to FIN with an error flag set; no memory access is made.
- Illegal cases:
  - funct3 not in the lists above (stores: only 000/001/010 legal).
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=0.
- REQ: mem_req=1 with mem_we, mem_addr, mem_wdata, mem_wstrb held stable until the edge where mem_ack=1.
  - On that edge, for a load, capture the extracted and extended data. Go to FIN.
- FIN lasts exactly one cycle, then returns to IDLE:
  - done=1.
  - err=flag.
  - wb_we=1 only if the op is a load, err=0 and rd≠0.
  - wb_rd is the latched rd; wb_data is the captured value.
  - Outside FIN, wb_we=0; wb_rd/wb_data hold their last values.
- Store strobes and data, with o = addr[1:0]:
  - SB: strobe 4'b0001<<o, wdata = {4{sd[7:0]}}.
  - SH: strobe 4'b0011<<o, wdata = {2{sd[15:0]}}.
  - SW: strobe 1111, wdata = sd.
- Load extraction: shifted = mem_rdata >> (8*o).
  - LB/LBU: sign- or zero-extend shifted[7:0].
  - LH/LHU: sign- or zero-extend shifted[15:0].
  - LW: mem_rdata unchanged.
- Latency:
  - Start edge at cycle 0: mem_req is high in cycle 1.
  - Ack sampled at cycle k≥1: FIN (done, wb_we) is in cycle k+1, and a new start can be accepted at the end of cycle k+1 edge+1, i.e. from IDLE at cycle k+2.
  - Error path: done/err in cycle 1.
- Boundaries:
  - start while busy: ignored, not queued.
  - mem_ack outside REQ: ignored.
  - rd=0 load: memory access is performed, done pulses, wb_we stays 0.
  - Reset during REQ: mem_req drops asynchronously, no write-back and no done.
  - Ack in the first REQ cycle is legal (zero wait).
- busy = (state≠IDLE).

Test Plan:
- LW: addr=0x100, rd=5, ack after 3 wait cycles with rdata=0xDEADBEEF.
  - Expect mem_addr=0x100, wstrb=0000.
  - Expect one cycle with wb_we=1, wb_rd=5, wb_data=0xDEADBEEF, done=1.
- LB and LBU at addr=0x103 with rdata=0x80123456.
  - LB: wb_data=0xFFFFFF80.
  - LBU: wb_data=0x00000080.
  - LHU at 0x102: wb_data=0x00008012.
- SB at addr=0x202, store_data=0x000000A5, zero-wait ack.
  - Expect mem_we=1, mem_addr=0x200, wstrb=0100, wdata=0xA5A5A5A5.
  - Expect done one cycle later, wb_we=0.
- Misaligned LW at addr=0x102 and SH at 0x101.
  - Expect no mem_req; cycle 1 done=1, err=1, wb_we=0.
- Load with rd=0: done pulses, wb_we never asserts.
  - Second start while busy: ignored, only one mem_req transaction.
- Assert rst mid-REQ: mem_req=0 immediately, all outputs zero, no done.
  - After release, a fresh LW completes normally.
